uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
- Shares the single uart_tx transmitter between NUM_REQ byte sources, e.g. mole-position reports, score updates and game-over notices.
- Round-robin arbitration. Issues one tx_start per byte, tracks tx_busy to completion, then enforces an inter-byte gap.
- Sits between the game-side message producers and the uart_tx instance in the top level.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- GAP_CYCLES, 16, idle clocks inserted after each completed byte (0 = none).
- START_TIMEOUT, 64, clocks to wait for tx_busy to rise after tx_start before declaring a fault.

Ports:
- clock  input  1  system clock (100 MHz).
- reset  input  1  synchronous, active-low reset.
- enable  input  1  high = new arbitration permitted; low = finish in-flight byte, accept nothing new.
- req  input  NUM_REQ  level request per source; held until that source's grant pulse.
- req_data  input  8*NUM_REQ  byte for source i on bits [8i+7:8i]; must be valid while req[i] is high.
- grant  output  NUM_REQ  one-hot, 1-cycle pulse: source's byte captured.
- done  output  NUM_REQ  one-hot, 1-cycle pulse: source's byte fully shifted out.
- fault  output  1  1-cycle pulse: tx_busy never rose within START_TIMEOUT.
- active_id  output  3  index of the source owning the transmitter; 0 when idle.
- sched_busy  output  1  high in every state except IDLE.
- tx_start  output  1  1-cycle start pulse to uart_tx.
- tx_data  output  8  byte to uart_tx; stable from tx_start until the next grant.
- tx_busy  input  1  busy flag from uart_tx.

Behaviour:
- All outputs registered.
- Reset (reset==0 at a clock edge) gives: state IDLE; grant, done, fault, tx_start = 0; tx_data = 0; active_id = 0; sched_busy = 0; rr pointer = 0.
- Reset mid-transfer abandons the byte. No done pulse. uart_tx is reset by the same signal.
- States: IDLE, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE, on an edge with enable==1 and req!=0:
  - Winner = first set bit searching upward from rr pointer, wrapping modulo NUM_REQ.
  - Register tx_data = winner's byte, active_id = winner, grant[winner] = 1, tx_start = 1.
  - rr pointer = (winner+1) mod NUM_REQ.
  - Go to WAIT_BUSY, with the timeout counter cleared.
  - Result: grant and tx_start are both high exactly one cycle after req is sampled (latency 1).
- IDLE with enable==0 or req==0: remain idle; no pulses.
- WAIT_BUSY:
  - tx_busy==1: go to WAIT_DONE.
  - Otherwise the counter increments. When it reaches START_TIMEOUT-1 without tx_busy, pulse fault and go to GAP. No done pulse.
- WAIT_DONE: when tx_busy==0, pulse done[active_id] and go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES clocks, then go to IDLE. The earliest next grant is one cycle after IDLE is re-entered.
- req is not sampled outside IDLE.
- A requester must drop req[i] on the edge after it sees grant[i]. A req still high on return to IDLE is treated as a new byte.
- The rr pointer advances only on a grant, so a continuously requesting source cannot starve the others.
- Simultaneous requests: exactly one grant per arbitration, chosen by the rr search.
- enable falling mid-transfer does not abort; the byte completes normally.
- NUM_REQ==1: the rr pointer stays 0.
- active_id is held through GAP, then returns to 0 in IDLE.

Test Plan:
- Reset: hold reset low 5 cycles with req=3'b111 -> all outputs 0, no tx_start. After release, grant=3'b001 and tx_data=req_data[7:0] one cycle after the first sampled edge.
- Single byte: req[1]=1 with data 8'h48, uart_tx model busy for 100 cycles -> one tx_start, tx_data=8'h48, grant=3'b010, done=3'b010 the cycle after busy falls. Next grant no earlier than 16+1 cycles later.
- Round-robin: all three req held high for 3 bytes -> grant order 0,1,2. A fourth request from source 0 only -> grant 0. Each grant is followed by done before the next tx_start.
- Timeout: tx_busy tied 0 after req[2] -> fault pulses 64 cycles after tx_start, no done, returns to IDLE after the gap, and the next request is served.
- Enable gating: drop enable during WAIT_DONE -> that byte's done still pulses. A pending req gets no grant until enable=1, then is granted one cycle later.
- Reset mid-operation: assert reset during WAIT_DONE -> next cycle state IDLE, sched_busy=0, no done pulse, rr pointer 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one uart_tx between NUM_REQ byte
// sources. One tx_start per byte, waits for tx_busy to rise and fall, then
// inserts an idle gap before the next arbitration. All outputs are registered.
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 3,
    parameter int GAP_CYCLES    = 16,
    parameter int START_TIMEOUT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   fault,
    output logic [2:0]             active_id,
    output logic                   sched_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy
);

    localparam int TW = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(START_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST     = GW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t               state_q;
    logic [2:0]           rr_q;
    logic [TW-1:0]        tmo_cnt_q;
    logic [GW-1:0]        gap_cnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic                 fault_q;
    logic [2:0]           active_id_q;
    logic                 sched_busy_q;
    logic                 tx_start_q;
    logic [7:0]           tx_data_q;

    // Requests and bytes padded to 8 entries so a 3-bit index always fits.
    logic [7:0]           req_pad;
    logic [7:0]           req_bytes [8];

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pad
            if (gi < NUM_REQ) begin : g_real
                assign req_pad[gi]   = req[gi];
                assign req_bytes[gi] = req_data[8*gi +: 8];
            end else begin : g_tie
                assign req_pad[gi]   = 1'b0;
                assign req_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    logic                 found_d;
    logic [2:0]           winner_d;
    logic [2:0]           rr_d;
    logic [3:0]           pos;
    logic [3:0]           nxt;

    // Round-robin search: first set request at or above the pointer, wrapping.
    always_comb begin
        found_d  = 1'b0;
        winner_d = '0;
        pos      = '0;
        nxt      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_q} + 4'(k);
            if (pos >= 4'(NUM_REQ)) begin
                pos = pos - 4'(NUM_REQ);
            end
            if (!found_d && req_pad[pos[2:0]]) begin
                found_d  = 1'b1;
                winner_d = pos[2:0];
            end
        end
        nxt = {1'b0, winner_d} + 4'd1;
        if (nxt >= 4'(NUM_REQ)) begin
            nxt = '0;
        end
        rr_d = nxt[2:0];
    end

    // Scheduler FSM: arbitration, start/busy handshake, timeout and gap timing.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rr_q         <= '0;
            tmo_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            fault_q      <= 1'b0;
            active_id_q  <= '0;
            sched_busy_q <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            grant_q    <= '0;
            done_q     <= '0;
            fault_q    <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable && found_d) begin
                        tx_data_q    <= req_bytes[winner_d];
                        active_id_q  <= winner_d;
                        grant_q      <= NUM_REQ'(1) << winner_d;
                        tx_start_q   <= 1'b1;
                        rr_q         <= rr_d;
                        tmo_cnt_q    <= '0;
                        sched_busy_q <= 1'b1;
                        state_q      <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                        // Transmitter never acknowledged: report and back off.
                        fault_q <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            state_q      <= S_IDLE;
                            active_id_q  <= '0;
                            sched_busy_q <= 1'b0;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        done_q <= NUM_REQ'(1) << active_id_q;
                        if (GAP_CYCLES == 0) begin
                            state_q      <= S_IDLE;
                            active_id_q  <= '0;
                            sched_busy_q <= 1'b0;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_q      <= S_IDLE;
                        active_id_q  <= '0;
                        sched_busy_q <= 1'b0;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    active_id_q  <= '0;
                    sched_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign active_id  = active_id_q;
    assign sched_busy = sched_busy_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;

endmodule
